// File: rtl/chram_write_sched.sv
// chram_write_sched: write-port scheduler for the overlay character-index RAM (port A).
//
// Shares the single chram write port between NREQ requesters using round-robin
// arbitration, issuing at most one write per clock. All outputs are registered:
// a request seen at edge t yields wr_ena/wr_addr/wr_data and ack[k] after edge t,
// so the RAM write lands on edge t+1.
//
// Build option: define CHRAM_CLEAR_EN to include the bulk-clear engine
// (IDLE/CLEAR/DONE FSM). Without it, the block arbitrates permanently, clr_start
// and clr_char are ignored, and busy/clr_done are tied low. The port list is the
// same in both builds.
//
// Ports:
//   i_clk      clock, rising-edge
//   reset      synchronous, active-high
//   req        per-requester pending-write flags
//   req_addr   packed addresses, slice k = [k*AW +: AW]
//   req_data   packed data, slice k = [k*DW +: DW]
//   ack        one-cycle pulse per requester when its write is issued
//   wr_ena     chram wren_a
//   wr_addr    chram address_a
//   wr_data    chram data_a
//   clr_start  one-cycle pulse: fill the whole RAM with clr_char
//   clr_char   fill code, sampled with clr_start
//   busy       high while a clear is in progress
//   clr_done   one-cycle pulse when a clear completes

module chram_write_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 11,
    parameter int unsigned DW   = 8
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic               wr_ena,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    input  logic               clr_start,
    input  logic [DW-1:0]      clr_char,
    output logic               busy,
    output logic               clr_done
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [NREQ-1:0] ack_q, ack_d;
    logic            wr_ena_q, wr_ena_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    // ---------------- Round-robin arbiter ----------------
    // A requester acked last cycle is excluded so a held req is never written twice.
    logic [NREQ-1:0] elig;
    logic            gnt_valid;
    logic [PW-1:0]   gnt_idx;
    int unsigned     cand;

    logic [NREQ-1:0] arb_ack;
    logic [AW-1:0]   arb_addr;
    logic [DW-1:0]   arb_data;
    logic [PW-1:0]   arb_ptr;

    assign elig = req & ~ack_q;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr_q) + i) % NREQ;
            if (!gnt_valid && elig[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        arb_ack          = '0;
        arb_ack[gnt_idx] = gnt_valid;
        arb_addr         = req_addr[gnt_idx*AW +: AW];
        arb_data         = req_data[gnt_idx*DW +: DW];
        arb_ptr          = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
    end

`ifdef CHRAM_CLEAR_EN
    // ---------------- Clear engine ----------------
    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    // cnt is one bit wider than the address; the terminal compare stops it before wrap.
    localparam logic [AW:0] LastCnt = {1'b0, {AW{1'b1}}};

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] char_q, char_d;
    logic          busy_q, busy_d;
    logic          clr_done_q, clr_done_d;

    // State register
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clr_start beats any pending request in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (clr_start) state_d = StClear;
            StClear: if (cnt_q == LastCnt) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        ack_d      = '0;
        wr_ena_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ptr_d      = ptr_q;
        busy_d     = 1'b0;
        clr_done_d = 1'b0;
        cnt_d      = cnt_q;
        char_d     = char_q;
        case (state_q)
            StIdle: begin
                if (clr_start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    char_d = clr_char;
                end else if (gnt_valid) begin
                    ack_d     = arb_ack;
                    wr_ena_d  = 1'b1;
                    wr_addr_d = arb_addr;
                    wr_data_d = arb_data;
                    ptr_d     = arb_ptr;
                end
            end
            StClear: begin
                wr_ena_d  = 1'b1;
                wr_addr_d = cnt_q[AW-1:0];
                wr_data_d = char_q;
                busy_d    = 1'b1;
                cnt_d     = cnt_q + (AW + 1)'(1);
            end
            StDone: begin
                clr_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            cnt_q      <= '0;
            char_q     <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            char_q     <= char_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign busy     = busy_q;
    assign clr_done = clr_done_q;
`else
    // No clear engine: arbitrate every cycle.
    logic unused_clr;
    assign unused_clr = ^{clr_start, clr_char};

    always_comb begin
        ack_d     = arb_ack;
        wr_ena_d  = gnt_valid;
        wr_addr_d = gnt_valid ? arb_addr : wr_addr_q;
        wr_data_d = gnt_valid ? arb_data : wr_data_q;
        ptr_d     = gnt_valid ? arb_ptr : ptr_q;
    end

    assign busy     = 1'b0;
    assign clr_done = 1'b0;
`endif

    // ---------------- Registered write port ----------------
    always_ff @(posedge i_clk) begin
        if (reset) begin
            ack_q     <= '0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ptr_q     <= '0;
        end else begin
            ack_q     <= ack_d;
            wr_ena_q  <= wr_ena_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ptr_q     <= ptr_d;
        end
    end

    assign ack     = ack_q;
    assign wr_ena  = wr_ena_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_chram_write_sched.sv
// Directed testbench for chram_write_sched (NREQ=4, AW=11, DW=8).
// Outputs are sampled on the falling edge; inputs change right after sampling.

module tb_chram_write_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 11;
    localparam int unsigned DW   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               wr_ena;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               clr_start;
    logic [DW-1:0]      clr_char;
    logic               busy;
    logic               clr_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    chram_write_sched #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .i_clk     (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ack       (ack),
        .wr_ena    (wr_ena),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .clr_char  (clr_char),
        .busy      (busy),
        .clr_done  (clr_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (fields ena,busy,done,ack,addr,data)",
                     tag, got, exp);
        end
    endtask

    // {6'b0, wr_ena, busy, clr_done, ack[3:0], wr_addr[10:0], wr_data[7:0]}
    function automatic logic [31:0] pack(input logic e, input logic b, input logic d,
                                         input logic [NREQ-1:0] a, input logic [AW-1:0] ad,
                                         input logic [DW-1:0] da);
        return {6'b0, e, b, d, a, ad, da};
    endfunction

    function automatic logic [31:0] snap();
        return {6'b0, wr_ena, busy, clr_done, ack, wr_addr, wr_data};
    endfunction

    task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[k*AW +: AW] = a;
        req_data[k*DW +: DW] = d;
    endtask

    int ord [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    int hits [NREQ];

    initial begin
        reset     = 1'b1;
        req       = 4'b1111;
        clr_start = 1'b0;
        clr_char  = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            set_slot(k, AW'(k * 100 + 7), DW'(8'h10 + k));
            hits[k] = 0;
        end

        // 1: held reset with all requests pending
        repeat (3) begin
            @(negedge clk);
            check("reset", snap(), pack(0, 0, 0, 4'b0000, 11'd0, 8'h00));
        end

        // 2: lone requester gets one write every other clock
        reset = 1'b0;
        req   = 4'b0100;
        set_slot(2, 11'd331, 8'h2A);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("lone", snap(),
                  pack(i % 2 == 0, 0, 0, (i % 2 == 0) ? 4'b0100 : 4'b0000, 11'd331, 8'h2A));
        end
        req = 4'b0000;
        set_slot(2, 11'd207, 8'h12);
        @(negedge clk);
        check("drop_hold", snap(), pack(0, 0, 0, 4'b0000, 11'd331, 8'h2A));

        // 3: all requesting; ptr is 3 after the last grant to 2
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("rr", snap(), pack(1, 0, 0, NREQ'(1 << ord[j]), AW'(ord[j] * 100 + 7),
                                     DW'(8'h10 + ord[j])));
            for (int k = 0; k < int'(NREQ); k++) if (ack[k]) hits[k]++;
        end
        for (int k = 0; k < int'(NREQ); k++) check("rr_share", 32'(hits[k]), 32'd2);
        req = 4'b0000;
        @(negedge clk);
        check("idle_hold", snap(), pack(0, 0, 0, 4'b0000, 11'd207, 8'h12));

`ifdef CHRAM_CLEAR_EN
        // 4: full clear collides with req[0]; clear wins
        req       = 4'b0001;
        clr_start = 1'b1;
        clr_char  = 8'hA6;
        @(negedge clk);
        check("clr_start", snap(), pack(0, 1, 0, 4'b0000, 11'd207, 8'h12));
        clr_start = 1'b0;
        clr_char  = 8'h00;
        for (int a = 0; a < 2048; a++) begin
            @(negedge clk);
            check("clr_wr", snap(), pack(1, 1, 0, 4'b0000, AW'(a), 8'hA6));
        end
        @(negedge clk);
        check("clr_done", snap(), pack(0, 0, 1, 4'b0000, 11'd2047, 8'hA6));
        @(negedge clk);
        check("post_clr_ack", snap(), pack(1, 0, 0, 4'b0001, 11'd7, 8'h10));
        req = 4'b0000;
        @(negedge clk);
        check("post_clr_idle", snap(), pack(0, 0, 0, 4'b0000, 11'd7, 8'h10));

        // 5: reset aborts a clear after 100 writes
        clr_start = 1'b1;
        clr_char  = 8'h5A;
        @(negedge clk);
        check("clr2_start", snap(), pack(0, 1, 0, 4'b0000, 11'd7, 8'h10));
        clr_start = 1'b0;
        for (int a = 0; a < 100; a++) begin
            @(negedge clk);
            check("clr2_wr", snap(), pack(1, 1, 0, 4'b0000, AW'(a), 8'h5A));
        end
        reset = 1'b1;
        req   = 4'b0011;
        repeat (2) begin
            @(negedge clk);
            check("clr_abort", snap(), pack(0, 0, 0, 4'b0000, 11'd0, 8'h00));
        end
        reset = 1'b0;
        // ptr back at 0: requester 0 first, then 1, then back to 0
        @(negedge clk);
        check("rst_rr0", snap(), pack(1, 0, 0, 4'b0001, 11'd7, 8'h10));
        @(negedge clk);
        check("rst_rr1", snap(), pack(1, 0, 0, 4'b0010, 11'd107, 8'h11));
        @(negedge clk);
        check("rst_rr2", snap(), pack(1, 0, 0, 4'b0001, 11'd7, 8'h10));
        req = 4'b0000;
`else
        // 6: clear request ignored, requester 3 served normally
        req       = 4'b1000;
        clr_start = 1'b1;
        clr_char  = 8'hA6;
        @(negedge clk);
        check("noen_ack", snap(), pack(1, 0, 0, 4'b1000, 11'd307, 8'h13));
        clr_start = 1'b0;
        @(negedge clk);
        check("noen_gap", snap(), pack(0, 0, 0, 4'b0000, 11'd307, 8'h13));
        @(negedge clk);
        check("noen_ack2", snap(), pack(1, 0, 0, 4'b1000, 11'd307, 8'h13));
        req = 4'b0000;
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
